param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//  Parametrised synchronous up/down modulo counter. Successor to the 4-bit up/down counter.
//  Adds configurable width, modulus and reset value; count enable; synchronous parallel load;
//  terminal-count and wrap outputs. Used as a general divider/sequencer in lab designs.
// PARAMETERS
//  WIDTH      8             counter width in bits (>=2)
//  MAX_VAL    2**WIDTH-1    highest count value; the modulus is MAX_VAL+1 (MAX_VAL <= 2**WIDTH-1)
//  RESET_VAL  0             count value on reset (must be <= MAX_VAL)
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high reset
//  en        in   1      count enable
//  up_down   in   1      1 = count up, 0 = count down
//  load      in   1      synchronous load strobe
//  load_val  in   WIDTH  value to load
//  saturate  in   1      present only when UDC_SATURATE_EN is defined (see CONFIGURATION)
//  count     out  WIDTH  registered counter value
//  tc        out  1      terminal count, combinational:
//                        (up_down ? count==MAX_VAL : count==0)
//  wrap      out  1      registered one-cycle pulse; set when the edge just taken wrapped count
// BEHAVIOUR
//  - Reset: asserted at any time, count=RESET_VAL and wrap=0 immediately, without waiting for clk.
//    Reset mid-count discards the operation in progress. First update is on the first clk edge
//    after deassert.
//  - Priority at each rising clk edge: reset > load > en > hold.
//  - load=1: count <= min(load_val, MAX_VAL), so out-of-range values clamp to MAX_VAL.
//    wrap <= 0. en and up_down are ignored.
//  - en=1, load=0, up_down=1:
//    count==MAX_VAL -> count <= 0, wrap <= 1; else count <= count+1, wrap <= 0.
//  - en=1, load=0, up_down=0:
//    count==0 -> count <= MAX_VAL, wrap <= 1; else count <= count-1, wrap <= 0.
//  - en=0, load=0: count holds, wrap <= 0.
//  - Latency: count and wrap reflect the inputs one clk edge after sampling.
//    tc follows count and up_down combinationally with zero cycles of latency.
//  - Arithmetic: all compares are unsigned and WIDTH bits wide. No intermediate value is wider
//    than WIDTH+1 bits. count never leaves 0..MAX_VAL.
//  - up_down may change on any cycle; the new direction applies at the next edge. No dead cycle.
// CONFIGURATION
//  - UDC_SATURATE_EN defined: adds input `saturate`.
//    With saturate=1, a count step that would wrap instead holds at the boundary:
//    MAX_VAL when counting up, 0 when counting down. wrap stays 0.
//    With saturate=1, load still works and still clamps.
//    saturate=0 gives the wrapping behaviour above.
//  - UDC_SATURATE_EN undefined: there is no `saturate` port and the counter always wraps.
// TESTING (WIDTH=4, MAX_VAL=9, RESET_VAL=0 unless noted)
//  1. Up wrap: reset 1 -> 0, then en=1, up_down=1 for 12 edges
//     -> count 1..9,0,1,2; wrap=1 only after the 9->0 edge; tc=1 while count==9.
//  2. Down wrap: from count=0, en=1, up_down=0 for 3 edges
//     -> count 9,8,7; wrap pulses once after the 0->9 edge; tc=1 while at 0 before that edge.
//  3. Load: load=1, load_val=7 with en=1 -> count=7 (load wins over en).
//     load_val=12 -> count=9 (clamp). wrap=0 on both edges.
//  4. Hold/direction: en=0 for 5 edges -> count unchanged.
//     Toggle up_down every edge with en=1 from 5 -> 6,5,6,5.
//  5. Async reset mid-count: assert reset between edges at count=6
//     -> count=0 and wrap=0 before the next edge; count resumes from 0 after release.
//     Repeat with RESET_VAL=3 -> count=3.
//  6. UDC_SATURATE_EN, saturate=1: count up from 8 for 3 edges -> 9,9,9 with wrap=0, tc=1.
//     Down from 1 for 3 edges -> 0,0,0.

Source files
------------

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with enable, clamping parallel load, tc and wrap.
// Define UDC_SATURATE_EN to add the `saturate` input (hold at boundary instead of wrapping).
module param_updown_counter #(
  parameter int unsigned     WIDTH     = 8,
  parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UDC_SATURATE_EN
  input  logic             saturate,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             sat;
  logic             at_max, at_zero;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;

`ifdef UDC_SATURATE_EN
  assign sat = saturate;
`else
  assign sat = 1'b0;
`endif

  assign at_max  = (count == MAXV);
  assign at_zero = (count == '0);
  assign tc      = up_down ? at_max : at_zero;

  always_comb begin
    cnt_nxt  = count;
    wrap_nxt = 1'b0;
    if (load) begin
      cnt_nxt = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      if (up_down) begin
        if (at_max) begin
          // saturating mode parks at the boundary and suppresses the wrap pulse
          cnt_nxt  = sat ? MAXV : '0;
          wrap_nxt = ~sat;
        end else begin
          cnt_nxt = count + ONE;
        end
      end else begin
        if (at_zero) begin
          cnt_nxt  = sat ? '0 : MAXV;
          wrap_nxt = ~sat;
        end else begin
          cnt_nxt = count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RSTV;
      wrap  <= 1'b0;
    end else begin
      count <= cnt_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter (WIDTH=4, MAX_VAL=9), two instances with
// RESET_VAL 0 and 3 sharing stimulus; a modulo-arithmetic model feeds an expectation queue.
module tb_param_updown_counter;

  localparam int W   = 4;
  localparam int MV  = 9;
  localparam int MOD = MV + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0, up_down = 1'b0, load = 1'b0, saturate = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count0, count3;
  logic         tc0, tc3, wrap0, wrap3;

  param_updown_counter #(.WIDTH(W), .MAX_VAL(MV), .RESET_VAL(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
`ifdef UDC_SATURATE_EN
    .saturate(saturate),
`endif
    .count(count0), .tc(tc0), .wrap(wrap0));

  param_updown_counter #(.WIDTH(W), .MAX_VAL(MV), .RESET_VAL(3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .load_val(load_val),
`ifdef UDC_SATURATE_EN
    .saturate(saturate),
`endif
    .count(count3), .tc(tc3), .wrap(wrap3));

  always #5 clk = ~clk;

  typedef struct {
    int c0, c3;
    bit w0, w3, t0, t3;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   m0 = 0, m3 = 3;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one step of a modulo-MOD counter expressed as plain integer arithmetic.
  function automatic void step(input int c, input bit ld, input int lv, input bit e,
                               input bit ud, input bit s, output int nc, output bit w);
    int t;
    nc = c;
    w  = 1'b0;
    if (ld) nc = (lv > MV) ? MV : lv;
    else if (e) begin
      t = ud ? c + 1 : c - 1;
      if (t < 0 || t > MV) begin
        if (s) nc = c;
        else begin
          nc = (t + MOD) % MOD;
          w  = 1'b1;
        end
      end else nc = t;
    end
  endfunction

  task automatic cyc(input bit r, input bit e, input bit ud, input bit ld, input int lv,
                     input bit s);
    exp_t x;
    bit   w0, w3, se;
    @(negedge clk);
    #1;
    reset    = r;
    en       = e;
    up_down  = ud;
    load     = ld;
    load_val = W'(lv);
    saturate = s;
`ifdef UDC_SATURATE_EN
    se = s;
`else
    se = 1'b0;
`endif
    if (r) begin
      #1;
      chk("async_rst_count0", int'(count0), 0);
      chk("async_rst_count3", int'(count3), 3);
      chk("async_rst_wrap0", int'(wrap0), 0);
      chk("async_rst_wrap3", int'(wrap3), 0);
      m0 = 0; m3 = 3; w0 = 1'b0; w3 = 1'b0;
    end else begin
      step(m0, ld, lv, e, ud, se, m0, w0);
      step(m3, ld, lv, e, ud, se, m3, w3);
    end
    x.c0 = m0; x.c3 = m3; x.w0 = w0; x.w3 = w3;
    x.t0 = ud ? (m0 == MV) : (m0 == 0);
    x.t3 = ud ? (m3 == MV) : (m3 == 0);
    sb.push_back(x);
  endtask

  // Monitor: outputs are valid every cycle; compare half a cycle after each edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count0", int'(count0), e.c0);
        chk("count3", int'(count3), e.c3);
        chk("wrap0", int'(wrap0), int'(e.w0));
        chk("wrap3", int'(wrap3), int'(e.w3));
        chk("tc0", int'(tc0), int'(e.t0));
        chk("tc3", int'(tc3), int'(e.t3));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    repeat (12) cyc(0, 1, 1, 0, 0, 0);          // up through 9 -> 0 wrap
    cyc(0, 0, 0, 1, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, 0);           // down through 0 -> 9 wrap
    cyc(0, 1, 1, 1, 7, 0);                      // load beats enable
    cyc(0, 1, 0, 1, 12, 0);                     // clamp to MAX_VAL
    cyc(0, 0, 1, 1, 15, 0);
    cyc(0, 0, 1, 1, 5, 0);
    repeat (5) cyc(0, 0, 1, 0, 0, 0);           // hold
    for (int i = 0; i < 4; i++) cyc(0, 1, (i % 2) == 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);                      // count 6
    cyc(1, 1, 1, 0, 0, 0);                      // async reset between edges
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 9, 0);
    cyc(0, 1, 1, 0, 0, 0);                      // wrap pulse then reset over it
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
`ifdef UDC_SATURATE_EN
    cyc(0, 0, 1, 1, 8, 1);
    repeat (3) cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 1);
    repeat (3) cyc(0, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 1, 14, 1);                     // load still clamps when saturating
    cyc(0, 1, 1, 0, 0, 0);                      // saturate off -> wraps again
`endif
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 40) == 0, ($urandom % 4) != 0, $urandom % 2,
          ($urandom % 6) == 0, $urandom_range(0, 15), $urandom % 2);
    end
    repeat (2) @(negedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
